// File: rtl/bus_copy_master.sv
// bus_copy_master
//   Bus initiator that copies a block of 32-bit words from a source byte
//   address to a destination byte address over one req/ack/resp port.
//   Reads are issued ahead while read data is buffered in a small FIFO.
//   Writes drain that FIFO and take priority over new reads.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-low reset
//   start_i                 one-cycle start pulse, honoured only when idle
//   src_addr_i, dst_addr_i  byte addresses; bits [1:0] are ignored
//   len_i                   number of words to copy (0 completes at once)
//   busy_o, done_o          transfer in progress / one-cycle completion
//   bus_req_o, bus_we_o     request valid / write (1) or read (0)
//   bus_addr_bo             word-aligned byte address
//   bus_be_bo, bus_wdata_bo byte enables (4'hF during requests), write data
//   bus_ack_i               request accepted when bus_req_o & bus_ack_i
//   bus_resp_i, bus_rdata_bi in-order read response and data
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing reads/writes until the last write is accepted
// DONE  | one-cycle completion pulse
module bus_copy_master #(
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [31:0]          bus_addr_bo,
  output logic [3:0]           bus_be_bo,
  output logic [31:0]          bus_wdata_bo,
  input  logic                 bus_ack_i,
  input  logic                 bus_resp_i,
  input  logic [31:0]          bus_rdata_bi
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] rd_left, wr_left;
  logic [31:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]        outstanding, fifo_cnt;
  logic [PW-1:0]        head, tail;
  logic [31:0]          mem [FIFO_DEPTH];
  logic                 hold_q, hold_we_q;

  logic                 in_run, start_acc, write_elig, read_elig, sel_we, req;
  logic                 rd_acc, wr_acc, push;
  logic [CW:0]          occ;

  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  assign in_run     = (state == S_RUN);
  assign start_acc  = (state == S_IDLE) & start_i;
  assign occ        = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign write_elig = in_run & (fifo_cnt != '0);
  // Counting outstanding reads against free FIFO space reserves a slot for
  // every response, so the FIFO can never overflow.
  assign read_elig  = in_run & (rd_left != '0) & (occ < DEPTH_C);
  // A request presented but not yet accepted keeps its direction; the held
  // choice stays eligible because nothing else consumes its resources.
  assign sel_we     = hold_q ? hold_we_q : write_elig;
  assign req        = write_elig | read_elig;
  assign rd_acc     = req & ~sel_we & bus_ack_i;
  assign wr_acc     = req & sel_we & bus_ack_i;
  assign push       = in_run & bus_resp_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_i) state_nx = (len_i == '0) ? S_DONE : S_RUN;
      S_RUN:  if (wr_acc && (wr_left == LEN_WIDTH'(1))) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o       = in_run;
    done_o       = (state == S_DONE);
    bus_req_o    = req;
    bus_we_o     = req & sel_we;
    bus_addr_bo  = '0;
    bus_be_bo    = 4'h0;
    bus_wdata_bo = '0;
    if (req) begin
      bus_addr_bo = sel_we ? wr_ptr : rd_ptr;
      bus_be_bo   = 4'hF;
      if (sel_we) bus_wdata_bo = mem[head];
    end
  end

  // Counters, pointers and request hold
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_left     <= '0;
      wr_left     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      hold_q      <= 1'b0;
      hold_we_q   <= 1'b0;
    end else if (start_acc) begin
      rd_left     <= len_i;
      wr_left     <= len_i;
      rd_ptr      <= {src_addr_i[31:2], 2'b00};
      wr_ptr      <= {dst_addr_i[31:2], 2'b00};
      outstanding <= '0;
      fifo_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      hold_q      <= 1'b0;
      hold_we_q   <= 1'b0;
    end else begin
      hold_q    <= in_run & req & ~bus_ack_i;
      hold_we_q <= sel_we;
      if (rd_acc) begin
        rd_left <= rd_left - LEN_WIDTH'(1);
        rd_ptr  <= rd_ptr + 32'd4;
      end
      if (wr_acc) begin
        wr_left <= wr_left - LEN_WIDTH'(1);
        wr_ptr  <= wr_ptr + 32'd4;
        head    <= head + PW'(1);
      end
      if (push) tail <= tail + PW'(1);
      case ({rd_acc, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({push, wr_acc})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Read-data storage; contents are only observed through fifo_cnt/head.
  always_ff @(posedge clk_i) begin
    if (push) mem[tail] <= bus_rdata_bi;
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// tb_bus_copy_master
//   Randomized bench for bus_copy_master. A responder/monitor process on the
//   falling edge plays the RAM, and compares every accepted request against
//   expected read/write transactions queued when a copy is started.
module tb_bus_copy_master;
  localparam int LW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   src_addr, dst_addr;
  logic [LW-1:0] len;
  logic          busy, done, req, we;
  logic [31:0]   addr, wdata;
  logic [3:0]    be;
  logic          ack, resp;
  logic [31:0]   rdata;

  bus_copy_master #(.LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len),
    .busy_o(busy), .done_o(done),
    .bus_req_o(req), .bus_we_o(we), .bus_addr_bo(addr),
    .bus_be_bo(be), .bus_wdata_bo(wdata),
    .bus_ack_i(ack), .bus_resp_i(resp), .bus_rdata_bi(rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Source memory: explicit words, otherwise a salted address hash.
  int unsigned src_mem[int unsigned];
  logic [31:0] salt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (src_mem.exists(a)) return src_mem[a];
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  // Scoreboard state
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [31:0] rq_data[$];
  int          rq_due[$];
  int          tb_out = 0, fifo_tb = 0, stale = 0;
  int          done_due = -1, busy_from = 0;
  bit          run_active = 0, txn_done = 0;
  int          ack_mode = 0, lat = 1;

  // Responder + monitor
  initial begin : monitor
    logic p_req, p_ack, p_we, have_prev, a, exp_done, exp_busy;
    logic [31:0] p_addr, p_wd;
    have_prev = 0;
    p_req = 0; p_ack = 0; p_we = 0; p_addr = 0; p_wd = 0;
    ack = 0; resp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("be", {28'd0, be}, req ? 32'hF : 32'h0);
        if (req) chk("addr_align", {30'd0, addr[1:0]}, 32'd0);
        exp_done = (done_due >= 0) && (cyc == done_due);
        exp_busy = run_active && (cyc >= busy_from) && !((done_due >= 0) && (cyc >= done_due));
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (exp_done) begin
          run_active = 0;
          done_due   = -1;
          txn_done   = 1;
        end
        if (have_prev && p_req && !p_ack) begin
          chk("stall_req", {31'd0, req}, 32'd1);
          chk("stall_we", {31'd0, we}, {31'd0, p_we});
          chk("stall_addr", addr, p_addr);
          if (p_we) chk("stall_wdata", wdata, p_wd);
        end
        case (ack_mode)
          0:       a = req;
          1:       a = req && (cyc % 2 == 0);
          default: a = req && ($urandom_range(0, 1) == 1);
        endcase
        ack = a;
        if (req && a) begin
          if (!we) begin
            if (exp_rd.size() == 0) fail_now("unexpected_read");
            else begin
              chk("rd_addr", addr, exp_rd.pop_front());
              rq_data.push_back(mem_rd(addr));
              rq_due.push_back(cyc + lat);
              tb_out++;
            end
          end else begin
            if (exp_wa.size() == 0) fail_now("unexpected_write");
            else begin
              chk("wr_addr", addr, exp_wa.pop_front());
              chk("wr_data", wdata, exp_wd.pop_front());
              fifo_tb--;
              if (exp_wa.size() == 0) done_due = cyc + 1;
            end
          end
        end
        p_req = req; p_ack = a; p_we = we; p_addr = addr; p_wd = wdata;
        have_prev = 1;
      end else begin
        ack = 0;
        have_prev = 0;
      end
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        resp  = 1;
        rdata = rq_data.pop_front();
        void'(rq_due.pop_front());
        if (stale > 0) stale--;
        else begin
          tb_out--;
          fifo_tb++;
        end
      end else begin
        resp  = 0;
        rdata = $urandom;
      end
      if (rst_n && run_active) begin
        checks++;
        if (tb_out + fifo_tb > DEPTH) begin
          failures++;
          $display("FAIL occupancy: got %0d expected <= %0d (cycle %0d)", tb_out + fifo_tb, DEPTH, cyc);
        end
      end
    end
  end

  // Issues a start pulse and queues the expected transactions.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit check_first);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    @(posedge clk); #2;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(sa + 32'(4 * i));
      exp_wa.push_back(da + 32'(4 * i));
      exp_wd.push_back(mem_rd(sa + 32'(4 * i)));
    end
    txn_done   = 0;
    run_active = (n > 0);
    busy_from  = cyc + 1;
    done_due   = (n == 0) ? cyc + 1 : -1;
    src_addr = s; dst_addr = d; len = LW'(n);
    start = 1;
    @(posedge clk); #2;
    start = 0;
    src_addr = $urandom; dst_addr = $urandom; len = LW'($urandom);
    if (check_first) begin
      @(negedge clk);
      chk("first_req", {31'd0, req}, (n > 0) ? 32'd1 : 32'd0);
      if (n > 0) begin
        chk("first_we", {31'd0, we}, 32'd0);
        chk("first_addr", addr, sa);
      end
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (!txn_done && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    if (!txn_done) fail_now("timeout_waiting_done");
    repeat (3) @(posedge clk);
    chk("rd_left_over", exp_rd.size(), 32'd0);
    chk("wr_left_over", exp_wa.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_req"}, {31'd0, req}, 32'd0);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_be"}, {28'd0, be}, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
  endtask

  initial begin : stimulus
    int n, k;
    rst_n = 0; start = 0; src_addr = 0; dst_addr = 0; len = 0;
    salt = $urandom;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst_n = 1;
    repeat (2) @(posedge clk);

    // single word, immediate responder
    src_mem[32'h100] = 32'hDEADBEEF;
    ack_mode = 0; lat = 1;
    start_copy(32'h100, 32'h200, 1, 1);
    wait_done(100);

    // zero length
    start_copy(32'h300, 32'h400, 0, 1);
    wait_done(20);

    // slow responder with ack on alternate cycles
    ack_mode = 1; lat = 3;
    start_copy(32'h1000, 32'h2000, 8, 0);
    wait_done(400);

    // address wrap and ignored low bits
    ack_mode = 0; lat = 1;
    start_copy(32'hFFFFFFF8, 32'h13, 4, 1);
    wait_done(100);

    // second start while running is ignored
    ack_mode = 2; lat = 2;
    start_copy(32'h5000, 32'h6000, 6, 0);
    repeat (2) @(posedge clk);
    #2;
    src_addr = 32'h7000; dst_addr = 32'h8000; len = 3; start = 1;
    @(posedge clk); #2;
    start = 0;
    wait_done(400);

    // reset with two reads outstanding
    ack_mode = 0; lat = 4;
    start_copy(32'h9000, 32'hA000, 10, 0);
    k = 0;
    while (tb_out < 2 && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (tb_out < 2) fail_now("timeout_outstanding");
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk_all_zero("midreset");
    stale = rq_due.size();
    tb_out = 0; fifo_tb = 0;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    run_active = 0; done_due = -1;
    @(posedge clk); #2;
    rst_n = 1;
    k = 0;
    while (rq_due.size() > 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (rq_due.size() > 0) fail_now("timeout_late_resp");
    repeat (3) @(posedge clk);
    lat = 1;
    start_copy(32'hB000, 32'hC000, 2, 1);
    wait_done(100);

    // randomized copies
    for (int t = 0; t < 8; t++) begin
      ack_mode = 2;
      lat = $urandom_range(1, 4);
      salt = $urandom;
      n = $urandom_range(1, 20);
      start_copy($urandom, $urandom, n, 1);
      wait_done(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator (master) for the single-port req/ack/resp memory protocol used by the team's RAM responders.
- Copies a block of 32-bit words from a source byte address to a destination byte address.
- Uses one bus port: read requests, in-order read responses buffered in a local FIFO, then write requests.
- Sits between a control register block (start/len/addresses) and any dual- or single-port RAM port.

Parameters:
- LEN_WIDTH, 16, width of the word-count field; max transfer is 2^LEN_WIDTH-1 words.
- FIFO_DEPTH, 4, read-data buffer entries; power of 2, minimum 2.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse; sampled only in IDLE.
- src_addr_i  in  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr_i  in  32  destination byte address; bits [1:0] ignored (treated as 0).
- len_i  in  LEN_WIDTH  number of words to copy.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle completion pulse.
- bus_req_o  out  1  request valid.
- bus_we_o  out  1  1 = write, 0 = read.
- bus_addr_bo  out  32  byte address, always word-aligned.
- bus_be_bo  out  4  byte enables; always 4'hF while bus_req_o is high, else 0.
- bus_wdata_bo  out  32  write data (FIFO head).
- bus_ack_i  in  1  request accepted this cycle when bus_req_o & bus_ack_i.
- bus_resp_i  in  1  read data valid; responses return in issue order, at least 1 cycle after acceptance.
- bus_rdata_bi  in  32  read data.

Behaviour:
- Reset (rst_i low, async): state IDLE; all counters, pointers and FIFO count cleared. Outputs: busy_o=0, done_o=0, bus_req_o=0, bus_we_o=0, bus_addr_bo=0, bus_be_bo=0, bus_wdata_bo=0.
- Reset mid-transfer abandons the transfer immediately. Responses arriving after reset release are ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE + start_i: latch src/dst (low bits cleared) and len.
    - len=0: go to DONE; no bus activity.
    - len>0: go to RUN.
  - RUN → DONE when the final write is accepted.
  - DONE → IDLE after one cycle. done_o=1 only in DONE.
- busy_o = (state==RUN). start_i outside IDLE is ignored.
- Counters:
  - rd_left (words not yet read-accepted), wr_left (words not yet write-accepted): both LEN_WIDTH.
  - outstanding (reads accepted, response pending).
  - fifo_cnt.
  - Read pointer rd_ptr and write pointer wr_ptr: 32-bit, +4 per accepted request, wrap modulo 2^32.
- Read issue: eligible when rd_left>0 and outstanding+fifo_cnt < FIFO_DEPTH. This guarantees every response has a slot; the FIFO never overflows.
- Write issue: eligible when fifo_cnt>0.
- Arbitration (combinational, in RUN):
  - Write has priority over read.
  - bus_req_o = write_elig | read_elig.
  - bus_we_o = write_elig.
  - bus_addr_bo = wr_ptr if writing, else rd_ptr.
- Requests hold stable while bus_ack_i is low. Arbitration is re-evaluated only after acceptance.
- On resp_i in RUN: push bus_rdata_bi into the FIFO and decrement outstanding.
- Same-cycle events:
  - Push and pop in the same cycle: fifo_cnt unchanged.
  - Read accept and response in the same cycle: outstanding unchanged.
- Latency:
  - start at cycle T → first read request visible at T+1.
  - Response at cycle R → write request for that word visible at R+1 at the earliest.
  - Final write accepted at cycle W → done_o=1 and busy_o=0 at W+1.
- bus_resp_i in IDLE/DONE is ignored.

Test Plan:
- Zero-cycle responder (ack=req, resp 1 cycle later); src=0x100, dst=0x200, len=1; memory[0x100]=0xDEADBEEF → read at T+1, write addr 0x200 data 0xDEADBEEF, done_o one cycle after write accept, busy_o low the same cycle.
- len=0 start → done_o pulse at T+1, bus_req_o never asserted, busy_o stays 0.
- len=8, FIFO_DEPTH=2, responder latency 3 cycles and ack withheld every other cycle → outstanding+fifo_cnt never exceeds 2, addr/we/wdata stable during stalls, dst holds the 8 src words in order.
- src=0xFFFFFFF8, dst=0x13 (low bits ignored → 0x10), len=4 → reads 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; writes 0x10–0x1C.
- start_i pulsed again during RUN with different len → ignored; exactly the original len writes.
- rst_i low for one cycle mid-transfer, with 2 reads outstanding → all outputs 0 immediately; late responses ignored; next start with len=2 completes normally.
